// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared button indices and repeat-FSM encodings
//
// Purpose: constants shared by the button conditioner and the mode FSM that
//          consumes its strobes.
// Contents: button channel indices, channel count, repeat-FSM state type.
package button_conditioner_pkg;

  localparam int N_BTN = 5;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_CENTER = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } rpt_state_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: synchronizer, debounce, press strobe, auto-repeat
//
// Purpose: conditions a single raw push-button into a debounced level and
//          one-cycle press strobes, optionally auto-repeating while held.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   raw    in   raw asynchronous button level, 1 = pressed
//   level  out  debounced registered level
//   pulse  out  registered one-cycle press / repeat strobe
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

  // Counters act on the "last" value rather than the full count so that the
  // transition happens on the cycle the count would reach the target.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              sync_in;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic              toggle;
  logic              rise, fall;
  rpt_state_t        state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_d;
  logic              rpt_pulse;

  assign sync_in = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Any cycle where the synchronized input agrees with the accepted level
  // restarts the count, so bounces shorter than the window are discarded.
  always_comb begin
    db_cnt_d = '0;
    toggle   = 1'b0;
    if (sync_in != level) begin
      if (db_cnt == DB_LAST) begin
        toggle = 1'b1;
      end else begin
        db_cnt_d = db_cnt + DB_W'(1);
      end
    end
  end

  assign rise = toggle & ~level;
  assign fall = toggle & level;

  // Repeat FSM tracks the level as it is being updated, so HOLD starts on
  // the same edge as the press strobe and a falling level cancels any
  // repeat strobe due that cycle.
  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    rep_cnt_d  = rep_cnt;
    rpt_pulse  = 1'b0;
    case (state)
      IDLE: begin
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        if (rise && REPEAT_EN) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d   = REPEAT;
          rep_cnt_d = '0;
          rpt_pulse = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt_d = '0;
          rpt_pulse = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt + REP_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt   <= '0;
      level    <= 1'b0;
      pulse    <= 1'b0;
      state    <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      db_cnt   <= db_cnt_d;
      level    <= level ^ toggle;
      pulse    <= rise | rpt_pulse;
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
      rep_cnt  <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and press strobes for the front-panel buttons
//
// Purpose: N_BTN independent button channels; channels selected by
//          REPEAT_MASK auto-repeat while held.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   btn_raw    in   raw button levels, 1 = pressed
//   btn_level  out  debounced registered levels
//   btn_pulse  out  one-cycle press / repeat strobes
module button_conditioner #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               HOLD_CYCLES     = 50000000,
  parameter int               REPEAT_CYCLES   = 20000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .pulse (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int NB = 5;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int            at;
    logic [NB-1:0] mask;
  } exp_t;
  exp_t sb[$];

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .REPEAT_MASK     (5'b11000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [NB-1:0] mask);
    exp_t e;
    e.at   = at;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every cycle the strobes must equal the OR of everything scheduled for it.
  always @(negedge clk) begin
    logic [NB-1:0] exp_mask;
    exp_mask = '0;
    while (sb.size() > 0 && sb[0].at == cyc) begin
      exp_mask |= sb[0].mask;
      void'(sb.pop_front());
    end
    chk("pulse", {27'd0, btn_pulse}, {27'd0, exp_mask});
  end

  initial begin
    int t0;
    rst     = 1'b0;
    btn_raw = '0;
    wait_cyc(3);
    chk("rst_level", {27'd0, btn_level}, 32'd0);
    rst = 1'b1;
    wait_cyc(3);

    // single press on right: strobe and level 6 edges later, no repeats
    t0 = cyc;
    btn_raw[1] = 1'b1;
    expect_pulse(t0 + 6, 5'b00010);
    wait_cyc(5);
    chk("r_level_pre", {31'd0, btn_level[1]}, 32'd0);
    wait_cyc(1);
    chk("r_level_up", {31'd0, btn_level[1]}, 32'd1);
    wait_cyc(19);
    btn_raw[1] = 1'b0;
    wait_cyc(5);
    chk("r_level_hold", {31'd0, btn_level[1]}, 32'd1);
    wait_cyc(1);
    chk("r_level_down", {31'd0, btn_level[1]}, 32'd0);
    wait_cyc(5);

    // bounce on center shorter than the debounce window
    for (int k = 0; k < 20; k++) begin
      btn_raw[2] = (k % 4) < 2;
      wait_cyc(1);
      chk("c_bounce_level", {31'd0, btn_level[2]}, 32'd0);
    end
    btn_raw[2] = 1'b0;
    wait_cyc(8);
    chk("c_bounce_final", {31'd0, btn_level[2]}, 32'd0);

    // up held: press, hold delay, repeats; fall at 31 cancels the due repeat
    t0 = cyc;
    btn_raw[3] = 1'b1;
    expect_pulse(t0 + 6, 5'b01000);
    expect_pulse(t0 + 16, 5'b01000);
    expect_pulse(t0 + 19, 5'b01000);
    expect_pulse(t0 + 22, 5'b01000);
    expect_pulse(t0 + 25, 5'b01000);
    expect_pulse(t0 + 28, 5'b01000);
    wait_cyc(25);
    btn_raw[3] = 1'b0;
    wait_cyc(5);
    chk("u_level_hold", {31'd0, btn_level[3]}, 32'd1);
    wait_cyc(1);
    chk("u_level_down", {31'd0, btn_level[3]}, 32'd0);
    wait_cyc(10);

    // second up press: hold/repeat timing restarts from IDLE
    t0 = cyc;
    btn_raw[3] = 1'b1;
    expect_pulse(t0 + 6, 5'b01000);
    expect_pulse(t0 + 16, 5'b01000);
    expect_pulse(t0 + 19, 5'b01000);
    expect_pulse(t0 + 22, 5'b01000);
    expect_pulse(t0 + 25, 5'b01000);
    wait_cyc(20);
    btn_raw[3] = 1'b0;
    wait_cyc(12);

    // down released one cycle before the repeat would start
    t0 = cyc;
    btn_raw[4] = 1'b1;
    expect_pulse(t0 + 6, 5'b10000);
    wait_cyc(9);
    btn_raw[4] = 1'b0;
    wait_cyc(5);
    chk("d_level_hold", {31'd0, btn_level[4]}, 32'd1);
    wait_cyc(1);
    chk("d_level_down", {31'd0, btn_level[4]}, 32'd0);
    wait_cyc(10);

    // left and right together
    t0 = cyc;
    btn_raw[1:0] = 2'b11;
    expect_pulse(t0 + 6, 5'b00011);
    wait_cyc(10);
    chk("lr_level", {30'd0, btn_level[1:0]}, 32'd3);
    btn_raw[1:0] = 2'b00;
    wait_cyc(12);

    // reset mid-debounce, button still held at release: one late press
    t0 = cyc;
    btn_raw[0] = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    #1;
    chk("rst_mid_level", {27'd0, btn_level}, 32'd0);
    wait_cyc(5);
    rst = 1'b1;
    expect_pulse(t0 + 14, 5'b00001);
    wait_cyc(20);
    chk("rst_mid_level_after", {31'd0, btn_level[0]}, 32'd1);
    btn_raw[0] = 1'b0;
    wait_cyc(12);

    // reset mid-repeat on up: due repeat aborted, held button re-pressed
    t0 = cyc;
    btn_raw[3] = 1'b1;
    expect_pulse(t0 + 6, 5'b01000);
    expect_pulse(t0 + 16, 5'b01000);
    wait_cyc(17);
    rst = 1'b0;
    wait_cyc(3);
    chk("rst_rpt_level", {27'd0, btn_level}, 32'd0);
    rst = 1'b1;
    expect_pulse(t0 + 26, 5'b01000);
    wait_cyc(7);
    btn_raw[3] = 1'b0;
    wait_cyc(15);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
